exec_stage_multi: RTL and testbench

- Parametrised N-lane execute stage for the superscalar core; successor to the fixed two-lane execute unit.
- Each lane takes decoded operands, runs an extended ALU and resolves branches/returns. Lanes are ordered by program age; lane 0 is oldest.
- Registers results into the EX/MEM boundary behind a valid/ready handshake.
- Supports a multi-cycle multiply and squashes lanes younger than the oldest taken branch.

---
 rtl/exec_stage_multi_if.sv | 39 +++
 rtl/exec_stage_multi.sv | 204 ++++++++++++++++++++
 tb/tb_exec_stage_multi.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_stage_multi_if.sv
// rtl/exec_stage_multi_if.sv - issue/result bundle interface for exec_stage_multi
interface exec_stage_multi_if #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_LANES-1:0]      in_lane_valid;
  logic [NUM_LANES*XLEN-1:0] in_pc;
  logic [NUM_LANES*XLEN-1:0] in_opA;
  logic [NUM_LANES*XLEN-1:0] in_opB;
  logic [NUM_LANES*4-1:0]    in_alu_ctl;
  logic [NUM_LANES-1:0]      in_is_branch;
  logic [NUM_LANES-1:0]      in_is_beq;
  logic [NUM_LANES-1:0]      in_is_bgt;
  logic [NUM_LANES-1:0]      in_is_ret;
  logic [NUM_LANES*XLEN-1:0] in_branch_target;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_LANES-1:0]      out_lane_valid;
  logic [NUM_LANES*XLEN-1:0] out_result;
  logic [NUM_LANES*XLEN-1:0] out_next_pc;
  logic                      redirect_valid;
  logic [XLEN-1:0]           redirect_pc;

  modport slave (
    input  in_valid, in_lane_valid, in_pc, in_opA, in_opB, in_alu_ctl,
           in_is_branch, in_is_beq, in_is_bgt, in_is_ret, in_branch_target, out_ready,
    output in_ready, out_valid, out_lane_valid, out_result, out_next_pc,
           redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, in_lane_valid, in_pc, in_opA, in_opB, in_alu_ctl,
           in_is_branch, in_is_beq, in_is_bgt, in_is_ret, in_branch_target, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_result, out_next_pc,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exec_stage_multi.sv
// rtl/exec_stage_multi.sv - N-lane execute stage with branch squash and optional multi-cycle MUL
// EXEC_MUL_EN enables opcode 1000 (MUL) and the MUL_BUSY/HOLD states; otherwise every bundle takes one cycle.
module exec_stage_multi #(
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  exec_stage_multi_if.slave   bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(MUL_LATENCY + 1);
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic                      accept, any_mul, load, capture, use_cap;
  logic [NUM_LANES-1:0]      cap_lv, cap_br, cap_beq, cap_bgt, cap_ret;
  logic [NUM_LANES*XLEN-1:0] cap_pc, cap_a, cap_b, cap_tgt;
  logic [NUM_LANES*4-1:0]    cap_ctl;
  logic [NUM_LANES-1:0]      src_lv, src_br, src_beq, src_bgt, src_ret;
  logic [NUM_LANES*XLEN-1:0] src_pc, src_a, src_b, src_tgt;
  logic [NUM_LANES*4-1:0]    src_ctl;
  logic [NUM_LANES*XLEN-1:0] res_c, npc_c;
  logic [NUM_LANES-1:0]      lv_c;
  logic                      rv_c, lane_tk;
  logic [XLEN-1:0]           rpc_c, lane_r, lane_np;

  function automatic logic [XLEN-1:0] alu(input logic [3:0] ctl, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (ctl)
      4'b0000: alu = a + b;
      4'b0001: alu = a - b;
      4'b0010: alu = a & b;
      4'b0011: alu = a | b;
      4'b0100: alu = a ^ b;
      4'b0101: alu = a << sh;
      4'b0110: alu = a >> sh;
      4'b0111: alu = $unsigned($signed(a) >>> sh);
      4'b1000: alu = MUL_EN ? a * b : '0;
      4'b1001: alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu = '0;
    endcase
  endfunction

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  // Outside IDLE the lanes are evaluated from the bundle captured at accept.
  assign use_cap      = (state != IDLE);
  assign src_lv  = use_cap ? cap_lv  : bus.in_lane_valid;
  assign src_br  = use_cap ? cap_br  : bus.in_is_branch;
  assign src_beq = use_cap ? cap_beq : bus.in_is_beq;
  assign src_bgt = use_cap ? cap_bgt : bus.in_is_bgt;
  assign src_ret = use_cap ? cap_ret : bus.in_is_ret;
  assign src_pc  = use_cap ? cap_pc  : bus.in_pc;
  assign src_a   = use_cap ? cap_a   : bus.in_opA;
  assign src_b   = use_cap ? cap_b   : bus.in_opB;
  assign src_tgt = use_cap ? cap_tgt : bus.in_branch_target;
  assign src_ctl = use_cap ? cap_ctl : bus.in_alu_ctl;

  always_comb begin
    any_mul = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      any_mul = any_mul | (MUL_EN && bus.in_lane_valid[i] && (bus.in_alu_ctl[i*4 +: 4] == 4'b1000));
  end

  // Lanes are walked oldest first; once a taken lane is seen every younger lane is squashed.
  always_comb begin
    res_c   = '0;
    npc_c   = '0;
    lv_c    = src_lv;
    rv_c    = 1'b0;
    rpc_c   = '0;
    lane_r  = '0;
    lane_np = '0;
    lane_tk = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_r  = alu(src_ctl[i*4 +: 4], src_a[i*XLEN +: XLEN], src_b[i*XLEN +: XLEN]);
      lane_np = src_pc[i*XLEN +: XLEN] + XLEN'(4);
      lane_tk = 1'b0;
      if (src_br[i]) begin
        if ((src_beq[i] && lane_r == '0) || (src_bgt[i] && $signed(lane_r) > 0)) begin
          lane_tk = 1'b1;
          lane_np = src_tgt[i*XLEN +: XLEN];
        end
      end else if (src_ret[i]) begin
        lane_tk = 1'b1;
        lane_np = lane_r;
      end
      res_c[i*XLEN +: XLEN] = lane_r;
      npc_c[i*XLEN +: XLEN] = lane_np;
      if (rv_c) begin
        lv_c[i] = 1'b0;
      end else if (lane_tk && src_lv[i]) begin
        rv_c  = 1'b1;
        rpc_c = lane_np;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (any_mul) begin
            state_n = MUL_BUSY;
            cnt_n   = CW'(MUL_LATENCY - 1);
            capture = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt == CW'(1)) begin
          cnt_n = '0;
          if (bus.out_valid && !bus.out_ready) begin
            state_n = HOLD;
          end else begin
            load    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (!bus.out_valid || bus.out_ready) begin
          load    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
      load    = 1'b0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_lv  <= '0; cap_br  <= '0; cap_beq <= '0; cap_bgt <= '0; cap_ret <= '0;
      cap_pc  <= '0; cap_a   <= '0; cap_b   <= '0; cap_tgt <= '0; cap_ctl <= '0;
    end else if (capture) begin
      cap_lv  <= bus.in_lane_valid;
      cap_br  <= bus.in_is_branch;
      cap_beq <= bus.in_is_beq;
      cap_bgt <= bus.in_is_bgt;
      cap_ret <= bus.in_is_ret;
      cap_pc  <= bus.in_pc;
      cap_a   <= bus.in_opA;
      cap_b   <= bus.in_opB;
      cap_tgt <= bus.in_branch_target;
      cap_ctl <= bus.in_alu_ctl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      bus.out_valid      <= 1'b0;
      bus.out_lane_valid <= '0;
      bus.out_result     <= '0;
      bus.out_next_pc    <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else if (load) begin
      bus.out_valid      <= 1'b1;
      bus.out_lane_valid <= lv_c;
      bus.out_result     <= res_c;
      bus.out_next_pc    <= npc_c;
      bus.redirect_valid <= rv_c;
      bus.redirect_pc    <= rpc_c;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_stage_multi.sv
// tb/tb_exec_stage_multi.sv - scoreboard bench for exec_stage_multi (directed cases plus random bundles)
module tb_exec_stage_multi;
  localparam int N  = 2;
  localparam int XL = 32;
  localparam int ML = 3;
`ifdef EXEC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]    lv;
    logic [N*XL-1:0] pc, a, b;
    logic [N*4-1:0]  ctl;
    logic [N-1:0]    br, beq, bgt, ret;
    logic [N*XL-1:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [N-1:0]    lv;
    logic [N*XL-1:0] res, npc;
    logic            rv;
    logic [XL-1:0]   rpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  bit   rand_done = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  exec_stage_multi_if #(.NUM_LANES(N), .XLEN(XL)) bus ();
  exec_stage_multi #(.NUM_LANES(N), .XLEN(XL), .MUL_LATENCY(ML)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_m(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return MUL_ON ? a * b : 32'd0;
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] r, np;
    logic tk;
    bit hit = 1'b0;
    e = '0;
    e.lv = s.lv;
    for (int i = 0; i < N; i++) begin
      r  = alu_m(s.ctl[i*4 +: 4], s.a[i*XL +: XL], s.b[i*XL +: XL]);
      np = s.pc[i*XL +: XL] + 32'd4;
      tk = 1'b0;
      if (s.br[i]) begin
        tk = (s.beq[i] && r == 32'd0) || (s.bgt[i] && !r[31] && r != 32'd0);
        if (tk) np = s.tgt[i*XL +: XL];
      end else if (s.ret[i]) begin
        tk = 1'b1;
        np = r;
      end
      e.res[i*XL +: XL] = r;
      e.npc[i*XL +: XL] = np;
      if (hit) e.lv[i] = 1'b0;
      else if (tk && s.lv[i]) begin
        hit   = 1'b1;
        e.rv  = 1'b1;
        e.rpc = np;
      end
    end
    return e;
  endfunction

  function automatic stim_t put(input stim_t s, input int i, input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic br, input logic beq, input logic bgt, input logic ret);
    s.lv[i] = 1'b1;
    s.ctl[i*4 +: 4] = c;
    s.a[i*XL +: XL] = a;
    s.b[i*XL +: XL] = b;
    s.pc[i*XL +: XL] = pc;
    s.tgt[i*XL +: XL] = tgt;
    s.br[i] = br; s.beq[i] = beq; s.bgt[i] = bgt; s.ret[i] = ret;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.in_lane_valid = s.lv;  bus.in_pc = s.pc;   bus.in_opA = s.a;  bus.in_opB = s.b;
    bus.in_alu_ctl = s.ctl;    bus.in_is_branch = s.br; bus.in_is_beq = s.beq;
    bus.in_is_bgt = s.bgt;     bus.in_is_ret = s.ret;   bus.in_branch_target = s.tgt;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input stim_t s, input bit push);
    bit done = 1'b0;
    drive(s);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (push) sb.push_back(model(s));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sb_lane_valid", 64'(bus.out_lane_valid), 64'(e.lv));
        chk("sb_result", 64'(bus.out_result), 64'(e.res));
        chk("sb_next_pc", 64'(bus.out_next_pc), 64'(e.npc));
        chk("sb_redirect_valid", 64'(bus.redirect_valid), 64'(e.rv));
        chk("sb_redirect_pc", 64'(bus.redirect_pc), 64'(e.rpc));
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
    int kind;
    s = '0;
    for (int i = 0; i < N; i++) begin
      kind = int'($urandom_range(0, 3));
      s = put(s, i, ops[$urandom_range(0, 11)],
              ($urandom_range(0, 1) != 0) ? 32'd0 - 32'($urandom_range(0, 8)) : 32'($urandom_range(0, 8)),
              32'($urandom_range(0, 8)), 32'h1000 + 32'(i * 4), 32'h8000 + 32'($urandom_range(0, 255) * 4),
              kind == 1 || kind == 2, kind == 1, kind == 2, kind == 3);
      s.lv[i] = ($urandom_range(0, 3) != 0);
    end
    return s;
  endfunction

  initial begin
    #500000;
    chk("watchdog", 64'd0, 64'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    stim_t s, sb_b;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_lane_valid", 64'(bus.out_lane_valid), 64'd0);
    chk("rst_result", 64'(bus.out_result), 64'd0);
    chk("rst_redirect", 64'({bus.redirect_valid, bus.redirect_pc}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    s = put('0, 0, 4'd0, 32'd5, 32'd7, 32'h100, 32'h0, 0, 0, 0, 0);
    s = put(s, 1, 4'd4, 32'hF0, 32'hFF, 32'h104, 32'h0, 0, 0, 0, 0);
    send(s, 1'b1);
    @(negedge clk);
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_result", 64'(bus.out_result), {32'h0F, 32'd12});
    chk("t1_next_pc", 64'(bus.out_next_pc), {32'h108, 32'h104});
    chk("t1_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    @(posedge clk); #1;

    s = put('0, 0, 4'd1, 32'd9, 32'd9, 32'h100, 32'h200, 1, 1, 0, 0);
    s = put(s, 1, 4'd0, 32'd1, 32'd2, 32'h104, 32'h0, 0, 0, 0, 0);
    send(s, 1'b1);
    @(negedge clk);
    chk("t2_redirect", 64'({bus.redirect_valid, bus.redirect_pc}), {31'd0, 1'b1, 32'h200});
    chk("t2_lane_valid", 64'(bus.out_lane_valid), 64'd1);
    @(posedge clk); #1;

    s = put('0, 0, 4'd1, 32'd3, 32'd5, 32'h100, 32'h500, 1, 0, 1, 0);
    s = put(s, 1, 4'd0, 32'h3000, 32'd0, 32'h104, 32'h0, 0, 0, 0, 1);
    send(s, 1'b1);
    @(negedge clk);
    chk("t3_npc0", 64'(bus.out_next_pc[31:0]), 64'h104);
    chk("t3_redirect", 64'({bus.redirect_valid, bus.redirect_pc}), {31'd0, 1'b1, 32'h3000});
    chk("t3_lane_valid", 64'(bus.out_lane_valid), 64'd3);
    @(posedge clk); #1;

    s = put('0, 0, 4'd8, 32'h10000, 32'h10000, 32'h100, 32'h0, 0, 0, 0, 0);
    send(s, 1'b1);
`ifdef EXEC_MUL_EN
    for (int c = 1; c < ML; c++) begin
      @(negedge clk);
      chk("t4_busy_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t4_busy_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
    end
`endif
    @(negedge clk);
    chk("t4_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_mul_wrap", 64'(bus.out_result[31:0]), 64'd0);
    @(posedge clk); #1;

    bus.out_ready = 1'b0;
    s = put('0, 0, 4'd0, 32'h11, 32'h22, 32'h200, 32'h0, 0, 0, 0, 0);
    send(s, 1'b1);
    sb_b = put('0, 0, 4'd0, 32'd1, 32'd1, 32'h300, 32'h0, 0, 0, 0, 0);
    drive(sb_b);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t5_hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t5_hold_result", 64'(bus.out_result[31:0]), 64'h33);
      chk("t5_hold_next_pc", 64'(bus.out_next_pc[31:0]), 64'h204);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_in_ready", 64'(bus.in_ready), 64'd1);
    sb.push_back(model(sb_b));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t5_next_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_next_result", 64'(bus.out_result[31:0]), 64'd2);
    @(posedge clk); #1;

    s = put('0, 0, 4'd0, 32'd4, 32'd4, 32'h400, 32'h0, 0, 0, 0, 0);
    drive(s);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("t6_flush_in_valid_ignored", 64'(bus.out_valid), 64'd0);
    chk("t6_flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

`ifdef EXEC_MUL_EN
    s = put('0, 0, 4'd8, 32'd3, 32'd3, 32'h500, 32'h0, 0, 0, 0, 0);
    send(s, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_mul_flush_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_mul_flush_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    send(s, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_rst_no_partial", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
    end
`endif
    s = put('0, 0, 4'd0, 32'd20, 32'd22, 32'h600, 32'h0, 0, 0, 0, 0);
    send(s, 1'b1);
    @(negedge clk);
    chk("t6_after_latency1", 64'(bus.out_valid), 64'd1);
    chk("t6_after_result", 64'(bus.out_result[31:0]), 64'd42);
    @(posedge clk); #1;

    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int t = 0; t < 40; t++) send(rand_stim(), 1'b1);
        rand_done = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
